mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Pipeline memory stage; consumes execute stage results (address in alu_result, store data = rs2).
//  Issues one data-bus request per load/store with valid/ready handshake, aligns bytes, extends loads.
//  Non-memory ops pass through unchanged with 1-cycle latency; commit_info rides alongside.
// PARAMETERS
//  WIDTH      64   data/address width (only 64 supported)
//  CINFO_W    161  commit_info width
// PORTS
//  clk             in   1        clock
//  rst             in   1        synchronous, active-high reset
//  in_valid        in   1        execute result valid
//  in_ready        out  1        stage can accept
//  in_ls_info      in   11       {lb,lh,lw,ld,lbu,lhu,lwu,sb,sh,sw,sd}, bit10=lb; one-hot or zero
//  in_alu_result   in   WIDTH    address (mem op) or ALU result (non-mem)
//  in_store_data   in   WIDTH    rs2 value
//  in_commit_info  in   CINFO_W  passthrough
//  out_valid       out  1        result valid to writeback
//  out_ready       in   1        writeback accepts
//  out_wb_data     out  WIDTH    load data / alu_result / 0 for stores
//  out_commit_info out  CINFO_W  registered passthrough
//  mem_req_valid   out  1        bus request
//  mem_req_ready   in   1        bus accepts request
//  mem_req_addr    out  WIDTH    {addr[63:3],3'b000}
//  mem_req_wen     out  1        1=store
//  mem_req_wdata   out  WIDTH    lane-shifted store data
//  mem_req_wstrb   out  8        byte enables (0 for loads)
//  mem_rsp_valid   in   1        response/ack
//  mem_rsp_rdata   in   WIDTH    read data, full 8-byte word
//  out_misalign    out  1        only with MEM_MISALIGN_TRAP_EN
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid, mem_req_valid, mem_req_wen, out_misalign=0; data/strb/addr=0.
//  FSM: IDLE->REQ (mem op accepted); REQ->WAIT (mem_req_valid&&mem_req_ready);
//       WAIT->DONE (mem_rsp_valid); DONE->IDLE (out_ready). Non-mem: IDLE->DONE on accept.
//  in_ready = (state==IDLE); accept = in_valid&&in_ready; fields latched on accept.
//  DONE asserts out_valid; outputs held stable until out_ready; DONE&&out_ready&&in_valid -> next
//   accept occurs the following cycle (no same-cycle bypass; max 1 op per 2 cycles).
//  REQ: mem_req_* stable while mem_req_valid && !mem_req_ready; valid never drops before handshake.
//  mem_rsp_valid ignored in IDLE/REQ/DONE; stores complete on ack, out_wb_data=0.
//  Lanes: off=addr[2:0]; size mask b=0x01,h=0x03,w=0x0F,d=0xFF; wstrb=(mask<<off)[7:0];
//   wdata=store_data<<(8*off). Load: raw=rdata>>(8*off); lb/lh/lw sign-extend bit 7/15/31;
//   lbu/lhu/lwu zero-extend; ld raw.
//  Latency: non-mem 1 cycle accept->out_valid; mem = 1 + req wait + rsp wait + 1.
//  rst mid-transaction: immediate return to IDLE, op dropped; bus is reset in same cycle.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: access with (off & (size-1))!=0 issues no bus request;
//   goes IDLE->DONE, out_misalign=1, out_wb_data=address. Port out_misalign exists only then.
//  Undefined: no check; bytes past lane 7 silently truncated (wstrb/wdata/rdata clipped).
// STRUCTURE
//  rv64_pkg: LS_* bit indices of ls_info, MS_IDLE/REQ/WAIT/DONE state encodings, size masks.
//  Sub-module mem_lane_align (combinational): off,size,signed,store_data,rdata -> wdata,wstrb,load_data.
// TESTING
//  ld addr=0x1000, rdata=0x8877665544332211 -> wstrb=0, wb_data=0x8877665544332211.
//  lb addr=0x1003, rdata=0x00000000F0000000 -> req_addr=0x1000, wb=0xFFFFFFFFFFFFFFF0; lbu -> 0xF0.
//  sh addr=0x2006, rs2=0xABCD -> wstrb=0xC0, wdata=0xABCD000000000000, wb=0.
//  ALU op alu_result=0x42 -> out_valid 1 cycle later, wb=0x42, no mem_req_valid.
//  mem_req_ready low 3 cycles, out_ready low 2 cycles -> req/out fields stable; single request.
//  rst in WAIT then stale mem_rsp_valid -> ignored, out_valid=0; misaligned lw 0x1002 traps iff macro.

Source files
------------

// File: rtl/rv64_pkg.sv
// Shared RV64 memory-stage types: ls_info bit indices, stage states, lane masks.
// Decode helpers map one-hot ls_info to byte masks, signedness and misalignment.
package rv64_pkg;

  localparam int LS_LB  = 10;
  localparam int LS_LH  = 9;
  localparam int LS_LW  = 8;
  localparam int LS_LD  = 7;
  localparam int LS_LBU = 6;
  localparam int LS_LHU = 5;
  localparam int LS_LWU = 4;
  localparam int LS_SB  = 3;
  localparam int LS_SH  = 2;
  localparam int LS_SW  = 1;
  localparam int LS_SD  = 0;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_REQ  = 2'd1,
    MS_WAIT = 2'd2,
    MS_DONE = 2'd3
  } ms_state_t;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  function automatic logic [7:0] ls_mask(
    input logic [10:0] ls
  );
    logic [7:0] m;
    m = 8'h00;
    unique case (1'b1)
      ls[LS_LB], ls[LS_LBU], ls[LS_SB]: m = MASK_B;
      ls[LS_LH], ls[LS_LHU], ls[LS_SH]: m = MASK_H;
      ls[LS_LW], ls[LS_LWU], ls[LS_SW]: m = MASK_W;
      ls[LS_LD], ls[LS_SD]:             m = MASK_D;
      default:                          m = 8'h00;
    endcase
    return m;
  endfunction

  function automatic logic ls_signed(
    input logic [10:0] ls
  );
    return ls[LS_LB] | ls[LS_LH] | ls[LS_LW];
  endfunction

  function automatic logic ls_misaligned(
    input logic [10:0] ls,
    input logic [2:0]  off
  );
    logic m;
    m = 1'b0;
    unique case (ls_mask(ls))
      MASK_H:  m = off[0];
      MASK_W:  m = |off[1:0];
      MASK_D:  m = |off;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_stage_lane_align.sv
// Byte-lane alignment for the memory stage: store shift/strobes and
// load extraction with sign/zero extension. Purely combinational.
module mem_lane_align
  import rv64_pkg::*;
(
  input  logic [2:0]  off,
  input  logic [7:0]  mask,
  input  logic        sgn,
  input  logic [63:0] store_data,
  input  logic [63:0] rdata,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic [63:0] load_data
);

  logic [15:0] strb_wide;
  logic [63:0] raw;
  logic [5:0]  sh;

  always_comb begin
    sh        = {off, 3'b000};
    strb_wide = {8'h00, mask} << off;
    // lanes past byte 7 fall off the top
    wstrb     = strb_wide[7:0];
    wdata     = store_data << sh;
    raw       = rdata >> sh;
    load_data = raw;
    unique case (mask)
      MASK_B: load_data = sgn ? {{56{raw[7]}}, raw[7:0]}
                              : {56'd0, raw[7:0]};
      MASK_H: load_data = sgn ? {{48{raw[15]}}, raw[15:0]}
                              : {48'd0, raw[15:0]};
      MASK_W: load_data = sgn ? {{32{raw[31]}}, raw[31:0]}
                              : {32'd0, raw[31:0]};
      default: load_data = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV64 memory stage: one bus request per load/store, lane align, extend.
// Build option MEM_MISALIGN_TRAP_EN adds out_misalign and skips misaligned accesses.
module mem_access_stage
  import rv64_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int CINFO_W = 161
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [10:0]        in_ls_info,
  input  logic [WIDTH-1:0]   in_alu_result,
  input  logic [WIDTH-1:0]   in_store_data,
  input  logic [CINFO_W-1:0] in_commit_info,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_wb_data,
  output logic [CINFO_W-1:0] out_commit_info,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [WIDTH-1:0]   mem_req_addr,
  output logic               mem_req_wen,
  output logic [WIDTH-1:0]   mem_req_wdata,
  output logic [7:0]         mem_req_wstrb,
  input  logic               mem_rsp_valid,
  input  logic [WIDTH-1:0]   mem_rsp_rdata
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic               out_misalign
`endif
);

  ms_state_t state_q, state_d;

  logic [10:0]        ls_q;
  logic [WIDTH-1:0]   addr_q;
  logic [WIDTH-1:0]   sdata_q;
  logic [WIDTH-1:0]   wb_q;
  logic [CINFO_W-1:0] ci_q;

  logic               accept;
  logic               is_mem_in;
  logic               is_store_q;
  logic               trap;
  logic [WIDTH-1:0]   wdata;
  logic [7:0]         wstrb;
  logic [WIDTH-1:0]   load_data;

  assign in_ready   = (state_q == MS_IDLE);
  assign accept     = in_valid && in_ready;
  assign is_mem_in  = |in_ls_info;
  assign is_store_q = |ls_q[LS_SB:LS_SD];

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q;
  assign trap = is_mem_in &&
                ls_misaligned(in_ls_info, in_alu_result[2:0]);
  assign out_misalign = mis_q;
`else
  assign trap = 1'b0;
`endif

  mem_lane_align u_align (
    .off        (addr_q[2:0]),
    .mask       (ls_mask(ls_q)),
    .sgn        (ls_signed(ls_q)),
    .store_data (sdata_q),
    .rdata      (mem_rsp_rdata),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .load_data  (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= MS_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MS_IDLE:
        if (accept)
          state_d = (!is_mem_in || trap) ? MS_DONE : MS_REQ;
      MS_REQ:
        if (mem_req_ready) state_d = MS_WAIT;
      MS_WAIT:
        if (mem_rsp_valid) state_d = MS_DONE;
      MS_DONE:
        if (out_ready) state_d = MS_IDLE;
      default: state_d = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ls_q    <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      wb_q    <= '0;
      ci_q    <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else if (accept) begin
      ls_q    <= in_ls_info;
      addr_q  <= in_alu_result;
      sdata_q <= in_store_data;
      ci_q    <= in_commit_info;
      // ALU result and trapped address both report the input word
      wb_q    <= in_alu_result;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q   <= trap;
`endif
    end else if (state_q == MS_WAIT && mem_rsp_valid) begin
      wb_q <= is_store_q ? '0 : load_data;
    end
  end

  assign out_valid       = (state_q == MS_DONE);
  assign out_wb_data     = wb_q;
  assign out_commit_info = ci_q;

  assign mem_req_valid = (state_q == MS_REQ);
  assign mem_req_addr  = {addr_q[WIDTH-1:3], 3'b000};
  assign mem_req_wen   = mem_req_valid && is_store_q;
  assign mem_req_wdata = wdata;
  assign mem_req_wstrb = is_store_q ? wstrb : 8'h00;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: bus responder and writeback
// monitor check against queued expectations; stimulus is directed.
module tb_mem_access_stage;

  localparam int CW = 161;

  localparam logic [10:0] LB  = 11'h400;
  localparam logic [10:0] LH  = 11'h200;
  localparam logic [10:0] LW  = 11'h100;
  localparam logic [10:0] LD  = 11'h080;
  localparam logic [10:0] LBU = 11'h040;
  localparam logic [10:0] LHU = 11'h020;
  localparam logic [10:0] LWU = 11'h010;
  localparam logic [10:0] SB  = 11'h008;
  localparam logic [10:0] SH  = 11'h004;
  localparam logic [10:0] SW  = 11'h002;
  localparam logic [10:0] SDW = 11'h001;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [10:0]   in_ls_info;
  logic [63:0]   in_alu_result;
  logic [63:0]   in_store_data;
  logic [CW-1:0] in_commit_info;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_wb_data;
  logic [CW-1:0] out_commit_info;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [63:0]   mem_req_addr;
  logic          mem_req_wen;
  logic [63:0]   mem_req_wdata;
  logic [7:0]    mem_req_wstrb;
  logic          mem_rsp_valid;
  logic [63:0]   mem_rsp_rdata;
`ifdef MEM_MISALIGN_TRAP_EN
  logic          out_misalign;
`endif

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_ls_info      (in_ls_info),
    .in_alu_result   (in_alu_result),
    .in_store_data   (in_store_data),
    .in_commit_info  (in_commit_info),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_wb_data     (out_wb_data),
    .out_commit_info (out_commit_info),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_req_wen     (mem_req_wen),
    .mem_req_wdata   (mem_req_wdata),
    .mem_req_wstrb   (mem_req_wstrb),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_rdata   (mem_rsp_rdata)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .out_misalign    (out_misalign)
`endif
  );

  typedef struct {
    logic [63:0]   wb;
    logic [CW-1:0] ci;
    logic          mis;
  } out_t;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] rdata;
  } req_t;

  out_t out_q[$];
  req_t req_q[$];

  int total = 0;
  int bad = 0;
  int req_stall = 0;
  int rsp_delay = 0;
  int out_stall = 0;
  int nreq = 0;
  int nreq_exp = 0;
  bit pend = 1'b0;

  function automatic logic [CW-1:0] mk_ci(input int id);
    return {33'h1_ABCD_EF01, 96'h0, 32'(id)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_ci(input string nm, input logic [CW-1:0] act,
                        input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_req(input logic [63:0] a, input logic w,
                            input logic [63:0] wd, input logic [7:0] ws,
                            input logic [63:0] rd);
    req_t r;
    r.addr = a; r.wen = w; r.wdata = wd; r.wstrb = ws; r.rdata = rd;
    req_q.push_back(r);
    nreq_exp++;
  endtask

  task automatic expect_out(input logic [63:0] wb, input int id,
                            input logic mis);
    out_t o;
    o.wb = wb; o.ci = mk_ci(id); o.mis = mis;
    out_q.push_back(o);
  endtask

  task automatic issue(input logic [10:0] ls, input logic [63:0] a,
                       input logic [63:0] sd, input int id);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_ls_info = ls;
    in_alu_result = a;
    in_store_data = sd;
    in_commit_info = mk_ci(id);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: id %0d not accepted", id);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(out_q.size() == 0 && req_q.size() == 0 && in_ready)
           && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL drain_timeout: out_q=%0d req_q=%0d",
               out_q.size(), req_q.size());
    end
  endtask

  // bus responder
  initial begin
    req_t r, snap;
    int st;
    int w;
    st = 0; w = 0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b0;
      if (pend) begin
        if (w == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = r.rdata;
          pend = 1'b0;
        end else w--;
      end
      if (mem_req_valid) begin
        if (st == 0) begin
          snap.addr = mem_req_addr; snap.wen = mem_req_wen;
          snap.wdata = mem_req_wdata; snap.wstrb = mem_req_wstrb;
        end else begin
          chk("stall_addr", mem_req_addr, snap.addr);
          chk("stall_wen", 64'(mem_req_wen), 64'(snap.wen));
          chk("stall_wdata", mem_req_wdata, snap.wdata);
          chk("stall_wstrb", 64'(mem_req_wstrb), 64'(snap.wstrb));
        end
        if (st < req_stall) st++;
        else begin
          mem_req_ready = 1'b1;
          st = 0;
          nreq++;
          if (req_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_req: addr %h", mem_req_addr);
          end else begin
            r = req_q.pop_front();
            chk("req_addr", mem_req_addr, r.addr);
            chk("req_wen", 64'(mem_req_wen), 64'(r.wen));
            chk("req_wdata", mem_req_wdata, r.wdata);
            chk("req_wstrb", 64'(mem_req_wstrb), 64'(r.wstrb));
            pend = 1'b1;
            w = rsp_delay;
          end
        end
      end
    end
  end

  // writeback monitor
  initial begin
    out_t e;
    int h;
    logic [63:0] swb;
    logic [CW-1:0] sci;
    h = 0; swb = '0; sci = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      out_ready = 1'b0;
      if (out_valid) begin
        if (h == 0) begin
          swb = out_wb_data;
          sci = out_commit_info;
        end else begin
          chk("hold_wb", out_wb_data, swb);
          chk_ci("hold_ci", out_commit_info, sci);
        end
        if (h < out_stall) h++;
        else begin
          out_ready = 1'b1;
          h = 0;
          if (out_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_out: wb %h", out_wb_data);
          end else begin
            e = out_q.pop_front();
            chk("wb_data", out_wb_data, e.wb);
            chk_ci("commit_info", out_commit_info, e.ci);
`ifdef MEM_MISALIGN_TRAP_EN
            chk("misalign", 64'(out_misalign), 64'(e.mis));
`endif
          end
        end
      end else h = 0;
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_ls_info = '0;
    in_alu_result = '0;
    in_store_data = '0;
    in_commit_info = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_req_wen", 64'(mem_req_wen), 64'd0);
    chk("rst_req_wstrb", 64'(mem_req_wstrb), 64'd0);
    chk("rst_req_addr", mem_req_addr, 64'd0);
    chk("rst_req_wdata", mem_req_wdata, 64'd0);
    chk("rst_wb_data", out_wb_data, 64'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("rst_misalign", 64'(out_misalign), 64'd0);
`endif
    rst = 1'b0;

    expect_req(64'h1000, 1'b0, 64'h0, 8'h00, 64'h8877665544332211);
    expect_out(64'h8877665544332211, 1, 1'b0);
    issue(LD, 64'h1000, 64'h0, 1);
    drain();

    expect_req(64'h1000, 1'b0, 64'h0, 8'h00, 64'h00000000F0000000);
    expect_out(64'hFFFFFFFFFFFFFFF0, 2, 1'b0);
    issue(LB, 64'h1003, 64'h0, 2);
    expect_req(64'h1000, 1'b0, 64'h0, 8'h00, 64'h00000000F0000000);
    expect_out(64'h00000000000000F0, 3, 1'b0);
    issue(LBU, 64'h1003, 64'h0, 3);
    drain();

    expect_req(64'h2000, 1'b1, 64'hABCD000000000000, 8'hC0, 64'h0);
    expect_out(64'h0, 4, 1'b0);
    issue(SH, 64'h2006, 64'hABCD, 4);
    drain();

    expect_out(64'h42, 5, 1'b0);
    issue(11'h000, 64'h42, 64'h0, 5);
    chk("alu_lat_valid", 64'(out_valid), 64'd1);
    chk("alu_no_req", 64'(mem_req_valid), 64'd0);
    drain();

    req_stall = 3; out_stall = 2; rsp_delay = 2;
    expect_req(64'h3000, 1'b1, 64'h5566778800000000, 8'hF0, 64'h0);
    expect_out(64'h0, 6, 1'b0);
    issue(SW, 64'h3004, 64'h1122334455667788, 6);
    drain();
    expect_req(64'h3008, 1'b0, 64'h0, 8'h00, 64'hCAFEBABE12345678);
    expect_out(64'hCAFEBABE12345678, 7, 1'b0);
    issue(LD, 64'h3008, 64'h0, 7);
    drain();
    req_stall = 0; out_stall = 0; rsp_delay = 0;

    expect_req(64'h10, 1'b0, 64'h0, 8'h00, 64'h0000000000008001);
    expect_out(64'hFFFFFFFFFFFF8001, 8, 1'b0);
    issue(LH, 64'h10, 64'h0, 8);
    expect_req(64'h10, 1'b0, 64'h0, 8'h00, 64'h0000000080010000);
    expect_out(64'h0000000000008001, 9, 1'b0);
    issue(LHU, 64'h12, 64'h0, 9);
    expect_req(64'h0, 1'b0, 64'h0, 8'h00, 64'h89ABCDEF00000000);
    expect_out(64'hFFFFFFFF89ABCDEF, 10, 1'b0);
    issue(LW, 64'h4, 64'h0, 10);
    expect_req(64'h0, 1'b0, 64'h0, 8'h00, 64'h89ABCDEF00000000);
    expect_out(64'h0000000089ABCDEF, 11, 1'b0);
    issue(LWU, 64'h4, 64'h0, 11);
    expect_req(64'h0, 1'b1, 64'h5A00000000000000, 8'h80, 64'h0);
    expect_out(64'h0, 12, 1'b0);
    issue(SB, 64'h7, 64'h5A, 12);
    expect_req(64'h8, 1'b1, 64'hDEADBEEFCAFEF00D, 8'hFF, 64'h0);
    expect_out(64'h0, 13, 1'b0);
    issue(SDW, 64'h8, 64'hDEADBEEFCAFEF00D, 13);
    drain();

    for (int i = 1; i <= 3; i++) begin
      expect_out(64'(i), 13 + i, 1'b0);
      issue(11'h000, 64'(i), 64'h0, 13 + i);
    end
    drain();

    rsp_delay = 4;
    expect_req(64'h500, 1'b0, 64'h0, 8'h00, 64'hFFFF);
    issue(LW, 64'h500, 64'h0, 20);
    n = 0;
    while (!pend && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_test_handshake", 64'(pend), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_req_valid", 64'(mem_req_valid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stale_rsp_out_valid", 64'(out_valid), 64'd0);
    end
    rsp_delay = 0;

`ifdef MEM_MISALIGN_TRAP_EN
    expect_out(64'h1002, 30, 1'b1);
`else
    expect_req(64'h1000, 1'b0, 64'h0, 8'h00, 64'h8877665544332211);
    expect_out(64'h0000000066554433, 30, 1'b0);
`endif
    issue(LW, 64'h1002, 64'h0, 30);
    drain();

    repeat (4) @(negedge clk);
    chk("req_count", 64'(nreq), 64'(nreq_exp));
    chk("out_q_empty", 64'(out_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
